// File: rtl/umi_pkg.sv
// Shared UMI definitions for the register endpoint: opcodes, command field
// layout and the endpoint FSM state type.
package umi_pkg;

   localparam logic [4:0] UMI_REQ_READ   = 5'h01;
   localparam logic [4:0] UMI_RESP_READ  = 5'h02;
   localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
   localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
   localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_W   = 5;
   localparam int SIZE_LSB   = 5;
   localparam int SIZE_W     = 3;
   localparam int LEN_LSB    = 8;
   localparam int LEN_W      = 8;
   // Low command bits that carry the decoded fields; the rest pass through.
   localparam int CMD_LO_W   = LEN_LSB + LEN_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

endpackage

// File: rtl/umi_reg_if_if.sv
// UMI device-side request/response channel bundle. The endpoint uses the
// slave view; the fabric (or a bench) uses the master view.
interface umi_reg_if_if #(
   parameter int CW = 32,
   parameter int AW = 64,
   parameter int DW = 256
);
   logic          udev_req_valid;
   logic          udev_req_ready;
   logic [CW-1:0] udev_req_cmd;
   logic [AW-1:0] udev_req_dstaddr;
   logic [AW-1:0] udev_req_srcaddr;
   logic [DW-1:0] udev_req_data;
   logic          udev_resp_valid;
   logic          udev_resp_ready;
   logic [CW-1:0] udev_resp_cmd;
   logic [AW-1:0] udev_resp_dstaddr;
   logic [AW-1:0] udev_resp_srcaddr;
   logic [DW-1:0] udev_resp_data;

   modport slave (
      input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
             udev_req_data, udev_resp_ready,
      output udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
             udev_resp_srcaddr, udev_resp_data
   );

   modport master (
      output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr,
             udev_req_data, udev_resp_ready,
      input  udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
             udev_resp_srcaddr, udev_resp_data
   );
endinterface

// File: rtl/umi_cmd_unpack.sv
// Splits the low UMI command bits into opcode/size/len and classifies the
// request kind. Purely combinational.
module umi_cmd_unpack
   import umi_pkg::*;
(
   input  logic [CMD_LO_W-1:0] cmd_i,
   output logic [OPCODE_W-1:0] opcode_o,
   output logic [SIZE_W-1:0]   size_o,
   output logic [LEN_W-1:0]    len_o,
   output logic                is_read_o,
   output logic                is_write_o,
   output logic                is_posted_o
);

   assign opcode_o = cmd_i[OPCODE_LSB +: OPCODE_W];
   assign size_o   = cmd_i[SIZE_LSB +: SIZE_W];
   assign len_o    = cmd_i[LEN_LSB +: LEN_W];

   // Anything that is not one of the three request opcodes decodes to "drop".
   always_comb begin
      is_read_o   = 1'b0;
      is_write_o  = 1'b0;
      is_posted_o = 1'b0;
      case (opcode_o)
         UMI_REQ_READ:   is_read_o   = 1'b1;
         UMI_REQ_WRITE:  is_write_o  = 1'b1;
         UMI_REQ_POSTED: is_posted_o = 1'b1;
         default: begin
            is_read_o   = 1'b0;
            is_write_o  = 1'b0;
            is_posted_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/umi_reg_if.sv
// UMI device endpoint driving a single-word register bus with 1-cycle read
// latency. One request in flight; reads and acked writes return a response.
module umi_reg_if
   import umi_pkg::*;
#(
   parameter int CW = 32,
   parameter int AW = 64,
   parameter int DW = 256,
   parameter int RW = 32
) (
   input  logic          clk,
   input  logic          reset,
   umi_reg_if_if.slave   udev,
   output logic [AW-1:0] reg_addr,
   output logic          reg_write,
   output logic          reg_read,
   output logic [4:0]    reg_opcode,
   output logic [2:0]    reg_size,
   output logic [7:0]    reg_len,
   output logic [RW-1:0] reg_wrdata,
   input  logic [RW-1:0] reg_rddata
);

   state_e                   state_q, state_d;
   logic [CW-1:CMD_LO_W]     cmd_hi_q, cmd_hi_d;
   logic [OPCODE_W-1:0]      opcode_q, opcode_d;
   logic [SIZE_W-1:0]        size_q, size_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [AW-1:0]            dst_q, dst_d;
   logic [AW-1:0]            src_q, src_d;
   logic [RW-1:0]            wrdata_q, wrdata_d;
   logic [RW-1:0]            rddata_q, rddata_d;
   logic                     is_read_q, is_read_d;
   logic                     is_write_q, is_write_d;
   logic                     resp_valid_q, resp_valid_d;
   logic                     reg_read_q, reg_read_d;
   logic                     reg_write_q, reg_write_d;

   logic [OPCODE_W-1:0]      in_opcode_s;
   logic [SIZE_W-1:0]        in_size_s;
   logic [LEN_W-1:0]         in_len_s;
   logic                     in_is_read_s, in_is_write_s, in_is_posted_s;
   logic [4:0]               resp_op_s;
   logic                     unused_req_data_s;

   umi_cmd_unpack u_unpack (
      .cmd_i       (udev.udev_req_cmd[CMD_LO_W-1:0]),
      .opcode_o    (in_opcode_s),
      .size_o      (in_size_s),
      .len_o       (in_len_s),
      .is_read_o   (in_is_read_s),
      .is_write_o  (in_is_write_s),
      .is_posted_o (in_is_posted_s)
   );

   // Only the low register word of the request data is ever written.
   assign unused_req_data_s = ^udev.udev_req_data[DW-1:RW];

   // Next-state and datapath capture for the IDLE/ACCESS/CAPTURE/RESP sequence.
   always_comb begin
      state_d      = state_q;
      cmd_hi_d     = cmd_hi_q;
      opcode_d     = opcode_q;
      size_d       = size_q;
      len_d        = len_q;
      dst_d        = dst_q;
      src_d        = src_q;
      wrdata_d     = wrdata_q;
      rddata_d     = rddata_q;
      is_read_d    = is_read_q;
      is_write_d   = is_write_q;
      resp_valid_d = resp_valid_q;
      reg_read_d   = 1'b0;
      reg_write_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (udev.udev_req_valid) begin
               cmd_hi_d    = udev.udev_req_cmd[CW-1:CMD_LO_W];
               opcode_d    = in_opcode_s;
               size_d      = in_size_s;
               len_d       = in_len_s;
               dst_d       = udev.udev_req_dstaddr;
               src_d       = udev.udev_req_srcaddr;
               wrdata_d    = udev.udev_req_data[RW-1:0];
               is_read_d   = in_is_read_s;
               is_write_d  = in_is_write_s;
               reg_read_d  = in_is_read_s;
               reg_write_d = in_is_write_s | in_is_posted_s;
               state_d     = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (is_read_q | is_write_q) begin
               state_d = ST_CAPTURE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            // Register data arrives one cycle after the read strobe.
            if (is_read_q) begin
               rddata_d = reg_rddata;
            end else begin
               rddata_d = {RW{1'b0}};
            end
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (udev.udev_resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // State and latched transaction registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cmd_hi_q     <= {(CW-CMD_LO_W){1'b0}};
         opcode_q     <= {OPCODE_W{1'b0}};
         size_q       <= {SIZE_W{1'b0}};
         len_q        <= {LEN_W{1'b0}};
         dst_q        <= {AW{1'b0}};
         src_q        <= {AW{1'b0}};
         wrdata_q     <= {RW{1'b0}};
         rddata_q     <= {RW{1'b0}};
         is_read_q    <= 1'b0;
         is_write_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         reg_read_q   <= 1'b0;
         reg_write_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_hi_q     <= cmd_hi_d;
         opcode_q     <= opcode_d;
         size_q       <= size_d;
         len_q        <= len_d;
         dst_q        <= dst_d;
         src_q        <= src_d;
         wrdata_q     <= wrdata_d;
         rddata_q     <= rddata_d;
         is_read_q    <= is_read_d;
         is_write_q   <= is_write_d;
         resp_valid_q <= resp_valid_d;
         reg_read_q   <= reg_read_d;
         reg_write_q  <= reg_write_d;
      end
   end

   // Response opcode follows the request kind latched at accept time.
   always_comb begin
      resp_op_s = UMI_RESP_WRITE;
      if (is_read_q) begin
         resp_op_s = UMI_RESP_READ;
      end else begin
         resp_op_s = UMI_RESP_WRITE;
      end
   end

   assign udev.udev_req_ready    = (state_q == ST_IDLE) && !reset;
   assign udev.udev_resp_valid   = resp_valid_q;
   assign udev.udev_resp_cmd     = {cmd_hi_q, len_q, size_q, resp_op_s};
   assign udev.udev_resp_dstaddr = src_q;
   assign udev.udev_resp_srcaddr = dst_q;
   assign udev.udev_resp_data    = {{(DW-RW){1'b0}}, rddata_q};

   assign reg_addr   = dst_q;
   assign reg_write  = reg_write_q;
   assign reg_read   = reg_read_q;
   assign reg_opcode = opcode_q;
   assign reg_size   = size_q;
   assign reg_len    = len_q;
   assign reg_wrdata = wrdata_q;

endmodule

// File: tb/tb_umi_reg_if.sv
// Directed + randomized bench for umi_reg_if with a 512-word register model
// and a response scoreboard queue.
module tb_umi_reg_if;
   import umi_pkg::*;

   localparam int CW = 32;
   localparam int AW = 64;
   localparam int DW = 256;
   localparam int RW = 32;
   localparam int MEM_WORDS = 512;

   typedef struct {
      logic [CW-1:0] cmd;
      logic [AW-1:0] dst;
      logic [AW-1:0] src;
      logic [DW-1:0] data;
   } resp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] reg_addr;
   logic          reg_write;
   logic          reg_read;
   logic [4:0]    reg_opcode;
   logic [2:0]    reg_size;
   logic [7:0]    reg_len;
   logic [RW-1:0] reg_wrdata;
   logic [RW-1:0] reg_rddata;

   logic [RW-1:0] mem [MEM_WORDS];
   logic [RW-1:0] exp_mem [MEM_WORDS];
   logic [RW-1:0] rd_q;
   resp_t         exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int resp_cnt = 0;
   int rdy_mode = 0;

   always #5 clk = ~clk;

   umi_reg_if_if #(.CW(CW), .AW(AW), .DW(DW)) udev ();

   umi_reg_if #(.CW(CW), .AW(AW), .DW(DW), .RW(RW)) dut (
      .clk        (clk),
      .reset      (reset),
      .udev       (udev.slave),
      .reg_addr   (reg_addr),
      .reg_write  (reg_write),
      .reg_read   (reg_read),
      .reg_opcode (reg_opcode),
      .reg_size   (reg_size),
      .reg_len    (reg_len),
      .reg_wrdata (reg_wrdata),
      .reg_rddata (reg_rddata)
   );

   // Synchronous register file, 1-cycle read latency
   always @(posedge clk) begin
      if (reg_write) mem[reg_addr[8:0]] <= reg_wrdata;
      if (reg_read)  rd_q <= mem[reg_addr[8:0]];
   end
   assign reg_rddata = rd_q;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Strobe counters
   always @(negedge clk) begin
      if (reg_write === 1'b1) wr_cnt++;
      if (reg_read === 1'b1)  rd_cnt++;
   end

   // Response-ready pacing
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       udev.udev_resp_ready = 1'b1;
         1:       udev.udev_resp_ready = 1'($urandom_range(0, 1));
         default: udev.udev_resp_ready = 1'b0;
      endcase
   end

   // Response monitor: every valid cycle must match the queue head
   always @(negedge clk) begin
      if (reset === 1'b0 && udev.udev_resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("resp_unexpected", udev.udev_resp_valid, 1'b0);
         end else begin
            chk("resp_cmd",  udev.udev_resp_cmd,     exp_q[0].cmd);
            chk("resp_dst",  udev.udev_resp_dstaddr, exp_q[0].dst);
            chk("resp_src",  udev.udev_resp_srcaddr, exp_q[0].src);
            chk("resp_data", udev.udev_resp_data,    exp_q[0].data);
            if (udev.udev_resp_ready === 1'b1) begin
               void'(exp_q.pop_front());
               resp_cnt++;
            end
         end
      end
   end

   // Issue one request; scoreboard/model updated at issue time
   task automatic send(input logic [4:0] op, input logic [AW-1:0] dst,
                       input logic [AW-1:0] src, input logic [RW-1:0] data);
      logic [CW-1:0] cmd;
      resp_t         e;
      bit            done;
      cmd = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)), 3'b010, op};
      e.cmd  = cmd;
      e.dst  = src;
      e.src  = dst;
      e.data = {DW{1'b0}};
      case (op)
         UMI_REQ_READ: begin
            e.cmd[4:0] = UMI_RESP_READ;
            e.data[RW-1:0] = exp_mem[dst[8:0]];
            exp_q.push_back(e);
         end
         UMI_REQ_WRITE: begin
            e.cmd[4:0] = UMI_RESP_WRITE;
            exp_mem[dst[8:0]] = data;
            exp_q.push_back(e);
         end
         UMI_REQ_POSTED: exp_mem[dst[8:0]] = data;
         default: ;
      endcase
      udev.udev_req_valid   = 1'b1;
      udev.udev_req_cmd     = cmd;
      udev.udev_req_dstaddr = dst;
      udev.udev_req_srcaddr = src;
      udev.udev_req_data    = {$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, data};
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (udev.udev_req_ready === 1'b1) done = 1'b1;
      end
      if (!done) chk("req_ready_timeout", udev.udev_req_ready, 1'b1);
      @(posedge clk);
      #1;
      udev.udev_req_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int w0, r0, c0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         mem[i] = {RW{1'b0}};
         exp_mem[i] = {RW{1'b0}};
      end
      reset = 1'b1;
      udev.udev_req_valid = 1'b0;
      udev.udev_req_cmd = {CW{1'b0}};
      udev.udev_req_dstaddr = {AW{1'b0}};
      udev.udev_req_srcaddr = {AW{1'b0}};
      udev.udev_req_data = {DW{1'b0}};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", udev.udev_req_ready, 1'b0);
      chk("rst_resp_valid", udev.udev_resp_valid, 1'b0);
      chk("rst_reg_write", reg_write, 1'b0);
      chk("rst_reg_read", reg_read, 1'b0);
      chk("rst_reg_addr", reg_addr, 64'h0);
      chk("rst_reg_opcode", reg_opcode, 5'h0);
      chk("rst_resp_data", udev.udev_resp_data, 256'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", udev.udev_req_ready, 1'b1);

      // Write then read with latency checks
      @(posedge clk); #1;
      send(UMI_REQ_WRITE, 64'h10, 64'h1000, 32'hDEADBEEF);
      @(negedge clk);
      chk("wr_strobe_t1", reg_write, 1'b1);
      chk("wr_addr", reg_addr, 64'h10);
      chk("wr_data", reg_wrdata, 32'hDEADBEEF);
      chk("wr_opcode", reg_opcode, UMI_REQ_WRITE);
      chk("wr_size", reg_size, 3'b010);
      chk("wr_resp_t1", udev.udev_resp_valid, 1'b0);
      chk("busy_req_ready", udev.udev_req_ready, 1'b0);
      @(negedge clk);
      chk("wr_strobe_t2", reg_write, 1'b0);
      chk("wr_resp_t2", udev.udev_resp_valid, 1'b0);
      @(negedge clk);
      chk("wr_resp_t3", udev.udev_resp_valid, 1'b1);
      drain(50);
      @(posedge clk); #1;
      send(UMI_REQ_READ, 64'h10, 64'h1000, 32'h0);
      @(negedge clk);
      chk("rd_strobe_t1", reg_read, 1'b1);
      chk("rd_expect_model", exp_q[0].data, 256'hDEADBEEF);
      drain(50);

      // Posted write: one strobe, no response
      w0 = wr_cnt; c0 = resp_cnt;
      @(posedge clk); #1;
      send(UMI_REQ_POSTED, 64'h20, 64'h2000, 32'h12345678);
      repeat (6) @(negedge clk);
      chk("posted_strobes", 32'(wr_cnt - w0), 32'd1);
      chk("posted_no_resp", 32'(resp_cnt - c0), 32'd0);
      @(posedge clk); #1;
      send(UMI_REQ_READ, 64'h20, 64'h2000, 32'h0);
      drain(50);

      // Backpressure: response held for 10 cycles
      c0 = resp_cnt;
      rdy_mode = 2;
      @(posedge clk); #1;
      send(UMI_REQ_READ, 64'h10, 64'h3000, 32'h0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_resp_valid", udev.udev_resp_valid, 1'b1);
         chk("bp_req_ready", udev.udev_req_ready, 1'b0);
      end
      rdy_mode = 0;
      drain(50);
      repeat (3) @(negedge clk);
      chk("bp_one_resp", 32'(resp_cnt - c0), 32'd1);
      chk("bp_resp_clear", udev.udev_resp_valid, 1'b0);

      // Unsupported opcode is swallowed
      w0 = wr_cnt; r0 = rd_cnt; c0 = resp_cnt;
      @(posedge clk); #1;
      send(5'h09, 64'h30, 64'h4000, 32'hCAFEF00D);
      repeat (6) @(negedge clk);
      chk("drop_no_wr", 32'(wr_cnt - w0), 32'd0);
      chk("drop_no_rd", 32'(rd_cnt - r0), 32'd0);
      chk("drop_no_resp", 32'(resp_cnt - c0), 32'd0);
      chk("drop_req_ready", udev.udev_req_ready, 1'b1);
      @(posedge clk); #1;
      send(UMI_REQ_WRITE, 64'h30, 64'h4000, 32'h0BADCAFE);
      drain(50);
      chk("after_drop_resp", 32'(resp_cnt - c0), 32'd1);

      // Reset during ACCESS aborts the read
      c0 = resp_cnt;
      @(posedge clk); #1;
      send(UMI_REQ_READ, 64'h10, 64'h5000, 32'h0);
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_req_ready", udev.udev_req_ready, 1'b0);
      chk("rst_mid_resp_valid", udev.udev_resp_valid, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_mid_no_resp", udev.udev_resp_valid, 1'b0);
      end
      chk("rst_mid_idle", udev.udev_req_ready, 1'b1);
      chk("rst_mid_addr_clr", reg_addr, 64'h0);
      chk("rst_mid_resp_cnt", 32'(resp_cnt - c0), 32'd0);

      // Random mixed traffic with random response pacing
      rdy_mode = 1;
      for (int n = 0; n < 1000; n++) begin
         int unsigned sel;
         int unsigned gap;
         logic [4:0]  op;
         sel = $urandom_range(0, 2);
         op = (sel == 0) ? UMI_REQ_READ : ((sel == 1) ? UMI_REQ_WRITE : UMI_REQ_POSTED);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < int'(gap); g++) @(posedge clk);
         if (gap != 0) #1;
         send(op, 64'($urandom_range(0, MEM_WORDS - 1)),
              {32'h0, $urandom}, $urandom);
      end
      drain(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
